// File: rtl/parking_gate_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parking_pkg
//  Description : Shared types and constants for the parking gate decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    localparam int DEFAULT_CAPACITY = 16;

    // Gate sequencer states: ENx walks an entering car, EXx an exiting car.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,
        EN2  = 3'd2,
        EN3  = 3'd3,
        EX1  = 3'd4,
        EX2  = 3'd5,
        EX3  = 3'd6
    } gate_state_t;

endpackage : parking_pkg
`default_nettype wire

// File: rtl/parking_gate_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_fsm_if
//  Description : Sensor inputs and event/occupancy outputs of the gate decoder.
//                master = sensor/tracker side, slave = gate decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface parking_gate_fsm_if #(
    parameter int CNT_W = 5
);
    logic             a;
    logic             b;
    logic             enter;
    logic             exit;
    logic             full;
    logic             empty;
    logic             error;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output a, b,
        input  enter, exit, full, empty, error, occupancy
    );

    modport slave (
        input  a, b,
        output enter, exit, full, empty, error, occupancy
    );
endinterface : parking_gate_fsm_if
`default_nettype wire

// File: rtl/parking_gate_fsm_sensor_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_synchronizer
//  Description : Two-flop synchronizer for one asynchronous photo-sensor.
//  Revision    : 1.0 - initial release
// ============================================================================
module sensor_synchronizer (
    input  wire  clk,
    input  wire  reset,
    input  wire  i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Two-stage resynchronisation; both stages clear on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule : sensor_synchronizer
`default_nettype wire

// File: rtl/parking_gate_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_fsm
//  Description : Decodes outer (a) / inner (b) gate sensors into one-cycle
//                enter/exit/error pulses and keeps lot occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_fsm
    import parking_pkg::*;
#(
    parameter int CAPACITY = DEFAULT_CAPACITY,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  wire               clk,
    input  wire               reset,
    parking_gate_fsm_if.slave gate
);
    localparam logic [CNT_W-1:0] c_CAPACITY = CNT_W'(CAPACITY);

    gate_state_t      r_state;
    logic             r_enter;
    logic             r_exit;
    logic             r_error;
    logic [CNT_W-1:0] r_occupancy;

    wire  [1:0]       w_pins;
    logic [1:0]       w_ab;
    wire              w_room;
    wire              w_any_car;

    assign w_pins = {gate.a, gate.b};

    // One synchronizer per sensor; w_ab[1] is a, w_ab[0] is b.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sensor
            sensor_synchronizer u_sync (
                .clk   (clk),
                .reset (reset),
                .i_d   (w_pins[gi]),
                .o_q   (w_ab[gi])
            );
        end
    endgenerate

    assign w_room    = (r_occupancy < c_CAPACITY);
    assign w_any_car = (r_occupancy != '0);

    // Sequencer with registered single-cycle event pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    case (w_ab)
                        2'b10:   r_state <= EN1;
                        2'b01:   r_state <= EX1;
                        2'b11:   r_error <= 1'b1;
                        default: r_state <= IDLE;
                    endcase
                end
                EN1: begin
                    case (w_ab)
                        2'b11:   r_state <= EN2;
                        2'b00:   r_state <= IDLE;
                        2'b01:   begin r_state <= IDLE; r_error <= 1'b1; end
                        default: r_state <= EN1;
                    endcase
                end
                EN2: begin
                    case (w_ab)
                        2'b01:   r_state <= EN3;
                        2'b10:   r_state <= EN1;
                        2'b00:   begin r_state <= IDLE; r_error <= 1'b1; end
                        default: r_state <= EN2;
                    endcase
                end
                EN3: begin
                    case (w_ab)
                        2'b00: begin
                            r_state <= IDLE;
                            // A full lot turns a completed entry into an overflow.
                            if (w_room) r_enter <= 1'b1;
                            else        r_error <= 1'b1;
                        end
                        2'b11:   r_state <= EN2;
                        2'b10:   begin r_state <= IDLE; r_error <= 1'b1; end
                        default: r_state <= EN3;
                    endcase
                end
                EX1: begin
                    case (w_ab)
                        2'b11:   r_state <= EX2;
                        2'b00:   r_state <= IDLE;
                        2'b10:   begin r_state <= IDLE; r_error <= 1'b1; end
                        default: r_state <= EX1;
                    endcase
                end
                EX2: begin
                    case (w_ab)
                        2'b10:   r_state <= EX3;
                        2'b01:   r_state <= EX1;
                        2'b00:   begin r_state <= IDLE; r_error <= 1'b1; end
                        default: r_state <= EX2;
                    endcase
                end
                EX3: begin
                    case (w_ab)
                        2'b00: begin
                            r_state <= IDLE;
                            // An empty lot turns a completed exit into an underflow.
                            if (w_any_car) r_exit  <= 1'b1;
                            else           r_error <= 1'b1;
                        end
                        2'b11:   r_state <= EX2;
                        2'b01:   begin r_state <= IDLE; r_error <= 1'b1; end
                        default: r_state <= EX3;
                    endcase
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Occupancy moves when a pulse cycle ends, so 'full' alongside 'enter'
    // still shows the pre-entry count. Bounds are rechecked to never wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occupancy <= '0;
        end else if (r_enter && (r_occupancy != c_CAPACITY)) begin
            r_occupancy <= r_occupancy + 1'b1;
        end else if (r_exit && (r_occupancy != '0)) begin
            r_occupancy <= r_occupancy - 1'b1;
        end
    end

    assign gate.enter     = r_enter;
    assign gate.exit      = r_exit;
    assign gate.error     = r_error;
    assign gate.occupancy = r_occupancy;
    assign gate.full      = (r_occupancy == c_CAPACITY);
    assign gate.empty     = (r_occupancy == '0);
endmodule : parking_gate_fsm
`default_nettype wire

// File: tb/tb_parking_gate_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_gate_fsm
//  Description : Scoreboard bench for parking_gate_fsm, two instances
//                (capacity 16 and 4) fed from the same sensor pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_fsm;

    localparam int c_CAP0 = 16;
    localparam int c_CAP1 = 4;

    typedef struct {
        int kind;        // 1 enter, 2 exit, 3 error
        int cyc;         // cycle at which the pulse is visible
        int occ_before;
        int occ_after;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parking_gate_fsm_if #(.CNT_W(5)) g0 ();
    parking_gate_fsm_if #(.CNT_W(3)) g1 ();

    parking_gate_fsm #(.CAPACITY(c_CAP0)) dut0 (.clk(clk), .reset(reset), .gate(g0.slave));
    parking_gate_fsm #(.CAPACITY(c_CAP1)) dut1 (.clk(clk), .reset(reset), .gate(g1.slave));

    // ---------------- reference model ----------------
    // A car is a point moving around the 4-step Gray ring of sensor codes;
    // the direction is fixed by the first code seen leaving 00.
    int   m_dir  = 0;   // 0 none, 1 entering, 2 exiting
    int   m_step = 0;
    int   m_occ [2];
    int   m_cap [2];
    exp_t q0 [$];
    exp_t q1 [$];
    int   pend_valid [2];
    int   pend_cyc   [2];
    int   pend_occ   [2];
    int   pulse_cnt = 0;

    function automatic int ring_pos(int d, logic [1:0] v);
        if (d == 1) begin
            case (v)
                2'b00: return 0;
                2'b10: return 1;
                2'b11: return 2;
                default: return 3;
            endcase
        end
        case (v)
            2'b00: return 0;
            2'b01: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic push_exp(int i, exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_reset();
        m_dir = 0; m_step = 0;
        m_occ[0] = 0; m_occ[1] = 0;
        q0.delete(); q1.delete();
        pend_valid[0] = 0; pend_valid[1] = 0;
    endtask

    task automatic model_step(logic [1:0] v);
        int evt = 0;
        int t;
        exp_t e;
        if (m_dir == 0) begin
            if (v == 2'b10)      begin m_dir = 1; m_step = 1; end
            else if (v == 2'b01) begin m_dir = 2; m_step = 1; end
            else if (v == 2'b11) evt = 3;
        end else begin
            t = ring_pos(m_dir, v);
            if (t == m_step) begin
                evt = 0;
            end else if (t == (m_step + 1) % 4) begin
                if (t == 0) begin evt = m_dir; m_dir = 0; end
                else m_step = t;
            end else if (t == (m_step + 3) % 4) begin
                if (t == 0) m_dir = 0;
                else m_step = t;
            end else begin
                evt = 3; m_dir = 0;
            end
        end
        if (evt != 0) begin
            for (int i = 0; i < 2; i++) begin
                e.cyc = cyc + 3;
                e.occ_before = m_occ[i];
                e.kind = evt;
                if (evt == 1 && m_occ[i] >= m_cap[i]) e.kind = 3;
                if (evt == 2 && m_occ[i] == 0)        e.kind = 3;
                if (e.kind == 1) m_occ[i]++;
                if (e.kind == 2) m_occ[i]--;
                e.occ_after = m_occ[i];
                push_exp(i, e);
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic mon(int i, logic en, logic ex, logic er, int occ, logic fl, logic em);
        exp_t e;
        int   pulse;
        int   kind;
        int   have;
        pulse = int'(en) + int'(ex) + int'(er);
        if (pend_valid[i] != 0 && pend_cyc[i] == cyc) begin
            chk($sformatf("occ_after_pulse[%0d]", i), occ, pend_occ[i]);
            pend_valid[i] = 0;
        end
        have = (i == 0) ? q0.size() : q1.size();
        if (pulse != 0) begin
            pulse_cnt++;
            chk($sformatf("one_hot_pulse[%0d]", i), pulse, 1);
            if (have == 0) begin
                chk($sformatf("unexpected_pulse[%0d]", i), pulse, 0);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                kind = en ? 1 : (ex ? 2 : 3);
                chk($sformatf("pulse_kind[%0d]", i), kind, e.kind);
                chk($sformatf("pulse_cycle[%0d]", i), cyc, e.cyc);
                chk($sformatf("occ_at_pulse[%0d]", i), occ, e.occ_before);
                chk($sformatf("full_at_pulse[%0d]", i), int'(fl), int'(e.occ_before == m_cap[i]));
                chk($sformatf("empty_at_pulse[%0d]", i), int'(em), int'(e.occ_before == 0));
                pend_valid[i] = 1;
                pend_cyc[i]   = cyc + 1;
                pend_occ[i]   = e.occ_after;
            end
        end else if (have != 0) begin
            e = (i == 0) ? q0[0] : q1[0];
            if (e.cyc < cyc) begin
                chk($sformatf("missed_pulse_kind%0d[%0d]", e.kind, i), pulse, 1);
                if (i == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0, g0.enter, g0.exit, g0.error, int'(g0.occupancy), g0.full, g0.empty);
            mon(1, g1.enter, g1.exit, g1.error, int'(g1.occupancy), g1.full, g1.empty);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_pins(logic [1:0] v);
        g0.a = v[1]; g0.b = v[0];
        g1.a = v[1]; g1.b = v[0];
    endtask

    task automatic drive(logic [1:0] v, int n);
        repeat (n) begin
            @(posedge clk); #1;
            set_pins(v);
            model_step(v);
        end
    endtask

    task automatic car(int entering, int hmin, int hmax);
        logic [1:0] seq [4];
        if (entering != 0) begin
            seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
        end else begin
            seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        end
        for (int k = 0; k < 4; k++) drive(seq[k], $urandom_range(hmax, hmin));
    endtask

    task automatic check_occ(string name, int o0, int o1);
        chk({name, "_occ16"}, int'(g0.occupancy), o0);
        chk({name, "_occ4"},  int'(g1.occupancy), o1);
    endtask

    initial begin
        int pc;
        m_cap[0] = c_CAP0;
        m_cap[1] = c_CAP1;
        model_reset();
        set_pins(2'b00);

        // Reset and idle
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check_occ("reset", 0, 0);
        chk("reset_empty16", int'(g0.empty), 1);
        chk("reset_full16",  int'(g0.full),  0);
        chk("reset_full4",   int'(g1.full),  0);
        pc = pulse_cnt;
        drive(2'b00, 10);
        chk("idle_no_pulse", pulse_cnt - pc, 0);

        // Directed entry then exit, then underflow
        car(1, 4, 4);
        drive(2'b00, 6);
        check_occ("after_entry", 1, 1);
        car(0, 4, 4);
        drive(2'b00, 6);
        check_occ("after_exit", 0, 0);
        chk("after_exit_empty", int'(g0.empty), 1);
        car(0, 4, 4);
        drive(2'b00, 6);
        check_occ("after_underflow", 0, 0);

        // Backout, then one-cycle 00->11 jump
        pc = pulse_cnt;
        drive(2'b10, 4); drive(2'b11, 4); drive(2'b10, 4); drive(2'b00, 6);
        chk("backout_no_pulse", pulse_cnt - pc, 0);
        drive(2'b11, 1); drive(2'b00, 6);
        chk("jump_one_error", pulse_cnt - pc, 2);

        // Five entries: capacity-4 instance overflows on the fifth
        for (int k = 0; k < 5; k++) begin
            car(1, 4, 4);
            drive(2'b00, 2);
        end
        drive(2'b00, 6);
        check_occ("five_entries", 5, 4);
        chk("full4_after", int'(g1.full), 1);

        // Async reset while in EN2, then 01,00
        drive(2'b10, 4); drive(2'b11, 4);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_occ("async_reset", 0, 0);
        chk("async_reset_enter", int'(g0.enter | g1.enter | g0.error | g1.error), 0);
        model_reset();
        set_pins(2'b00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        pc = pulse_cnt;
        drive(2'b01, 4); drive(2'b00, 6);
        chk("post_reset_no_pulse", pulse_cnt - pc, 0);

        // Randomized traffic: fill past capacity, then mixed activity
        for (int k = 0; k < 20; k++) begin
            car(1, 1, 3);
            drive(2'b00, $urandom_range(3, 1));
        end
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(3, 0))
                0: car(1, 1, 3);
                1: car(0, 1, 3);
                2: drive(2'($urandom_range(3, 0)), $urandom_range(3, 1));
                default: drive(2'b00, $urandom_range(3, 1));
            endcase
        end
        drive(2'b00, 8);
        chk("drain_q16", q0.size(), 0);
        chk("drain_q4",  q1.size(), 0);
        check_occ("final", m_occ[0], m_occ[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_parking_gate_fsm
`default_nettype wire
